// File: rtl/tcam_if.sv
// rtl/tcam_if.sv - write/search strobe bus and registered result of the ternary CAM
//
// Ports carried:
//   we, waddr, data, search   driven by the requester (master)
//   saddr, sdata, found       registered search result from the CAM (slave)
interface tcam_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] data;
  logic             search;
  logic [AW-1:0]    saddr;
  logic [WIDTH-1:0] sdata;
  logic             found;

  modport master (
    output we, waddr, data, search,
    input  saddr, sdata, found
  );

  modport slave (
    input  we, waddr, data, search,
    output saddr, sdata, found
  );
endinterface

// File: rtl/tcam_core.sv
// rtl/tcam_core.sv - ternary CAM, lowest-index match, one-cycle registered search
//
// Ports:
//   clk           rising-edge clock
//   rstN          asynchronous active-low reset; clears words, valid bits, results
//   bus.we        write strobe: mem[waddr] <= data, entry becomes valid
//   bus.waddr     write address
//   bus.data      write word, or search key when bus.search=1
//   bus.search    search strobe; result registered on the same edge
//   bus.saddr     lowest matching index (0 when nothing matched)
//   bus.sdata     stored word at saddr, verbatim (0 when nothing matched)
//   bus.found     1 when the last search matched a valid entry
//
// X/Z bits in a stored word or in the key are wildcards, so this is a
// 4-state simulation model rather than something meant for silicon.
module tcam_core #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rstN,
  tcam_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [DEPTH-1:0] valid;

  logic [DEPTH-1:0] hit;
  logic             hit_any;
  logic [AW-1:0]    hit_idx;

  // A bit is a don't-care if either side is X or Z; otherwise it must be
  // identical. Case-equality is what lets X/Z be recognised at all.
  function automatic logic bit_match(input logic s, input logic k);
    return (s === 1'bx) || (s === 1'bz) ||
           (k === 1'bx) || (k === 1'bz) || (s === k);
  endfunction

  // Match vector is built from the contents before the clock edge, so a word
  // written on the same edge as a search is not yet visible to it.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic all_bits;
      all_bits = 1'b1;
      for (int b = 0; b < WIDTH; b++) begin
        if (!bit_match(mem[i][b], bus.data[b])) all_bits = 1'b0;
      end
      hit[i] = valid[i] && all_bits;
    end
  end

  // Walk downwards so the lowest matching index is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid     <= '0;
      bus.found <= 1'b0;
      bus.saddr <= '0;
      bus.sdata <= '0;
    end else begin
      if (bus.we) begin
        mem[bus.waddr]   <= bus.data;
        valid[bus.waddr] <= 1'b1;
      end
      if (bus.search) begin
        bus.found <= hit_any;
        bus.saddr <= hit_idx;
        bus.sdata <= hit_any ? mem[hit_idx] : '0;
      end
    end
  end
endmodule

// File: tb/tb_tcam_core.sv
// tb/tb_tcam_core.sv - randomized self-checking bench for tcam_core against a table model
module tb_tcam_core;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  logic clk;
  logic rstN;

  tcam_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  tcam_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference table: a list of (valid, word) entries plus the last result.
  logic [WIDTH-1:0] m_word  [DEPTH];
  bit               m_valid [DEPTH];
  bit               m_found;
  int               m_addr;
  logic [WIDTH-1:0] m_data;

  function automatic bit is_wild(input logic v);
    return (v === 1'bx) || (v === 1'bz);
  endfunction

  function automatic bit entry_hits(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] k);
    for (int b = 0; b < WIDTH; b++)
      if (!(is_wild(w[b]) || is_wild(k[b]) || (w[b] === k[b]))) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_word[i]  = '0;
      m_valid[i] = 0;
    end
    m_found = 0;
    m_addr  = 0;
    m_data  = '0;
  endtask

  task automatic model_op(input bit w, input int a, input logic [WIDTH-1:0] d, input bit s);
    if (s) begin
      m_found = 0;
      m_addr  = 0;
      m_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && entry_hits(m_word[i], d)) begin
          m_found = 1;
          m_addr  = i;
          m_data  = m_word[i];
          break;
        end
      end
    end
    if (w) begin
      m_word[a]  = d;
      m_valid[a] = 1;
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, ".found"}, 32'(bus.found), 32'(m_found));
    check({tag, ".saddr"}, 32'(bus.saddr), 32'(m_addr));
    check({tag, ".sdata"}, 32'(bus.sdata), 32'(m_data));
  endtask

  // Drive one strobe for a single edge, then compare against the model.
  task automatic do_op(input string tag, input bit w, input int a,
                       input logic [WIDTH-1:0] d, input bit s);
    bus.we     = w;
    bus.waddr  = 4'(a);
    bus.data   = d;
    bus.search = s;
    @(posedge clk);
    #1;
    model_op(w, a, d, s);
    bus.we     = 1'b0;
    bus.search = 1'b0;
    check_result(tag);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s.mem%0d", tag, i), 32'(dut.mem[i]), 32'(m_word[i]));
  endtask

  function automatic logic [WIDTH-1:0] rand_word(input int xrate);
    logic [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    for (int b = 0; b < WIDTH; b++)
      if ($urandom_range(0, 99) < xrate) v[b] = 1'bx;
    return v;
  endfunction

  int               waddrs [6] = '{0, 1, 2, 5, 6, 9};
  logic [WIDTH-1:0] wwords [6] = '{16'b00x0101010000011, 16'b1111110010000000,
                                   16'b0000000010000x0x, 16'b00x01x1110xxxx00,
                                   16'b11x010x010000x0x, 16'b00x010x010010010};

  initial begin
    rstN       = 1'b0;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.data   = '0;
    bus.search = 1'b0;
    model_reset();
    #22;
    check("rst.found", 32'(bus.found), 32'd0);
    check("rst.saddr", 32'(bus.saddr), 32'd0);
    check("rst.sdata", 32'(bus.sdata), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    do_op("empty", 0, 0, 16'h0000, 1);
    check("empty.spec_found", 32'(bus.found), 32'd0);

    for (int i = 0; i < 6; i++) do_op($sformatf("wr%0d", i), 1, waddrs[i], wwords[i], 0);
    check_mem("load");

    do_op("s2", 0, 0, 16'b1111110010000000, 1);
    check("s2.spec_saddr", 32'(bus.saddr), 32'd1);
    check("s2.spec_sdata", 32'(bus.sdata), 32'(16'b1111110010000000));
    do_op("s3", 0, 0, 16'b1100101010xx0101, 1);
    do_op("s4", 0, 0, 16'b10x0101010000011, 1);
    check("s4.spec_found", 32'(bus.found), 32'd0);
    do_op("s5", 0, 0, 16'b0x10xx1110101000, 1);
    do_op("s5wr", 1, 3, 16'b0x10xx1110101000, 1);
    do_op("hold", 0, 0, 16'hffff, 0);
    do_op("s5after", 0, 0, 16'b0x10xx1110101000, 1);

    for (int n = 0; n < 300; n++) begin
      bit w, s;
      w = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) != 0);
      do_op($sformatf("rnd%0d", n), w, $urandom_range(0, DEPTH - 1),
            rand_word(w ? 10 : 20), s);
    end
    check_mem("rnd");

    // Make sure outputs are non-zero, then drop reset while a search is pending.
    for (int i = 0; i < DEPTH; i++) do_op("fill", 1, i, 16'h8000 | 16'(i), 0);
    do_op("prefill", 0, 0, 16'h8003, 1);
    bus.search = 1'b1;
    bus.data   = 16'h8005;
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check("midrst.found", 32'(bus.found), 32'd0);
    check("midrst.saddr", 32'(bus.saddr), 32'd0);
    check("midrst.sdata", 32'(bus.sdata), 32'd0);
    bus.search = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check_mem("midrst");
    do_op("postrst", 0, 0, 16'h8005, 1);
    do_op("postrst0", 0, 0, 16'h0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
